// File: rtl/mp3_pcm_pkg.sv
// Purpose: shared types and constants for the PCM RAM streamer (FSM states, word split).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mp3_pcm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Bits per channel; a RAM word carries {left, right}.
    localparam int SAMPLE_W  = 16;
    localparam int LEFT_MSB  = 31;
    localparam int RIGHT_MSB = 15;

endpackage

// File: rtl/mp3_pcm_sync_fifo.sv
// Purpose: generic show-ahead synchronous FIFO with occupancy count and flush.
// Latency: write visible at head one clk after push; head valid combinationally.
// Backpressure: caller must not push when full unless popping in the same clk; flush wins over push/pop.
module mp3_pcm_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_dat,
    output logic [CW-1:0]    count,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    // Next-state: storage write, pointer advance, occupancy update.
    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers; storage cleared on reset so the head reads 0 when idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign empty    = (count_q == '0);

endmodule

// File: rtl/mp3_pcm_ram_streamer.sv
// Purpose: reads packed stereo words from PCM RAM port 2 and streams L/R samples; optional PCM_STREAMER_UNDERRUN_CNT_EN adds underrun_cnt.
// Latency: RAM read 1 clk, sample at FIFO head the clk after the word returns (2 clk from issue).
// Backpressure: reads issue only while fifo_count + inflight < FIFO_DEPTH, so returned words always fit.
module mp3_pcm_ram_streamer #(
    parameter int ADDR_W     = 12,
    parameter int FIFO_DEPTH = 8,
    parameter int SAMPLE_W   = mp3_pcm_pkg::SAMPLE_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic                cfg_loop,
    input  logic [ADDR_W-1:0]   cfg_base,
    input  logic [ADDR_W-1:0]   cfg_len,
    output logic [ADDR_W-1:0]   ram_address,
    output logic                ram_chipselect,
    output logic                ram_clken,
    input  logic [31:0]         ram_readdata,
    output logic                sample_valid,
    input  logic                sample_ready,
    output logic [SAMPLE_W-1:0] sample_left,
    output logic [SAMPLE_W-1:0] sample_right,
    output logic                busy,
    output logic                done
`ifdef PCM_STREAMER_UNDERRUN_CNT_EN
    ,
    output logic [15:0]         underrun_cnt
`endif
);

    import mp3_pcm_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0]     OCC_MAX = (CW+1)'(FIFO_DEPTH);
    localparam logic [ADDR_W:0] REM_ONE = (ADDR_W+1)'(1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W:0]     rem_q, rem_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic                loop_q, loop_d;
    logic                stopped_q, stopped_d;
    logic                inflight_q, inflight_d;

    logic                issue, flush, done_pulse, pop;
    logic [CW:0]         occ;
    logic [CW-1:0]       fifo_count;
    logic                fifo_empty;
    logic [31:0]         head_dat;

    // Control FSM and address generator: start latches config, RUN issues reads, DRAIN waits out the tail.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        base_d     = base_q;
        rem_d      = rem_q;
        len_d      = len_q;
        loop_d     = loop_q;
        stopped_d  = stopped_q;
        issue      = 1'b0;
        flush      = 1'b0;
        done_pulse = 1'b0;
        occ        = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
        case (state_q)
            ST_IDLE: begin
                // stop in the same clk cancels the start
                if (start && !stop) begin
                    state_d   = ST_RUN;
                    base_d    = cfg_base;
                    ptr_d     = cfg_base;
                    loop_d    = cfg_loop;
                    stopped_d = 1'b0;
                    len_d     = (cfg_len == '0) ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, cfg_len};
                    rem_d     = (cfg_len == '0) ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, cfg_len};
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d   = ST_DRAIN;
                    stopped_d = 1'b1;
                end else if (occ < OCC_MAX) begin
                    issue = 1'b1;
                    if (rem_q == REM_ONE) begin
                        if (loop_q) begin
                            ptr_d = base_q;
                            rem_d = len_q;
                        end else begin
                            state_d = ST_DRAIN;
                        end
                    end else begin
                        ptr_d = ptr_q + ADDR_W'(1);
                        rem_d = rem_q - REM_ONE;
                    end
                end
            end
            ST_DRAIN: begin
                if (!inflight_q) begin
                    if (stopped_q) begin
                        flush   = 1'b1;
                        state_d = ST_IDLE;
                    end else if (fifo_empty) begin
                        done_pulse = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        inflight_d = issue;
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            base_q     <= '0;
            rem_q      <= '0;
            len_q      <= '0;
            loop_q     <= 1'b0;
            stopped_q  <= 1'b0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            base_q     <= base_d;
            rem_q      <= rem_d;
            len_q      <= len_d;
            loop_q     <= loop_d;
            stopped_q  <= stopped_d;
            inflight_q <= inflight_d;
        end
    end

    assign pop = sample_valid && sample_ready;

    mp3_pcm_sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (inflight_q),
        .push_dat (ram_readdata),
        .pop      (pop),
        .flush    (flush),
        .head_dat (head_dat),
        .count    (fifo_count),
        .empty    (fifo_empty)
    );

    assign ram_address    = ptr_q;
    assign ram_chipselect = issue;
    assign ram_clken      = issue;
    assign sample_valid   = !fifo_empty;
    assign sample_left    = head_dat[LEFT_MSB -: SAMPLE_W];
    assign sample_right   = head_dat[RIGHT_MSB -: SAMPLE_W];
    assign busy           = (state_q != ST_IDLE);
    assign done           = done_pulse;

`ifdef PCM_STREAMER_UNDERRUN_CNT_EN
    logic [15:0] urun_q, urun_d;

    // Count clks in RUN where the sink wants data but the FIFO has none; saturating.
    always_comb begin
        urun_d = urun_q;
        if ((state_q == ST_IDLE) && start && !stop) begin
            urun_d = '0;
        end else if ((state_q == ST_RUN) && sample_ready && fifo_empty && (urun_q != 16'hFFFF)) begin
            urun_d = urun_q + 16'd1;
        end
    end

    // Underrun counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            urun_q <= '0;
        end else begin
            urun_q <= urun_d;
        end
    end

    assign underrun_cnt = urun_q;
`endif

endmodule

// File: tb/tb_mp3_pcm_ram_streamer.sv
// Purpose: self-checking bench for mp3_pcm_ram_streamer against a sequence-level reference model.
// Latency: n/a (bench).
// Backpressure: sink ready driven fixed or randomized per scenario.
module tb_mp3_pcm_ram_streamer;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        cfg_loop = 1'b0;
    logic [11:0] cfg_base = '0;
    logic [11:0] cfg_len = '0;
    logic [11:0] ram_address;
    logic        ram_chipselect;
    logic        ram_clken;
    logic [31:0] ram_readdata = '0;
    logic        sample_valid;
    logic        sample_ready = 1'b0;
    logic [15:0] sample_left;
    logic [15:0] sample_right;
    logic        busy;
    logic        done;
`ifdef PCM_STREAMER_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    logic [31:0] ram_mem [4096];
    logic [31:0] got_q [$];
    int          addr_q [$];
    int          done_cnt = 0;
    int          clken_bad = 0;

    mp3_pcm_ram_streamer dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .stop           (stop),
        .cfg_loop       (cfg_loop),
        .cfg_base       (cfg_base),
        .cfg_len        (cfg_len),
        .ram_address    (ram_address),
        .ram_chipselect (ram_chipselect),
        .ram_clken      (ram_clken),
        .ram_readdata   (ram_readdata),
        .sample_valid   (sample_valid),
        .sample_ready   (sample_ready),
        .sample_left    (sample_left),
        .sample_right   (sample_right),
        .busy           (busy),
        .done           (done)
`ifdef PCM_STREAMER_UNDERRUN_CNT_EN
        ,
        .underrun_cnt   (underrun_cnt)
`endif
    );

    always #5 clk = ~clk;

    // RAM model: read data one clk after address + chipselect.
    always @(posedge clk) begin
        if (ram_chipselect) ram_readdata <= ram_mem[ram_address];
    end

    // Monitor away from the active edge: accepted samples, issued addresses, done pulses.
    always @(negedge clk) begin
        if (!reset) begin
            if (sample_valid && sample_ready) got_q.push_back({sample_left, sample_right});
            if (ram_chipselect) addr_q.push_back(int'(ram_address));
            if (done) done_cnt++;
        end
        if (ram_clken !== ram_chipselect) clken_bad++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        got_q.delete();
        addr_q.delete();
        done_cnt = 0;
    endtask

    task automatic launch(input logic [11:0] b, input logic [11:0] l, input logic lp);
        cfg_base = b;
        cfg_len  = l;
        cfg_loop = lp;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        cfg_base = 12'($urandom);
        cfg_len  = 12'($urandom);
        cfg_loop = 1'($urandom);
    endtask

    task automatic wait_idle(input int budget, input bit rnd, input string name);
        int n = 0;
        while (busy && n < budget) begin
            if (rnd) sample_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_idle: busy=%b after %0d clk, required 0", name, busy, n);
        end
    endtask

    // Reference: k-th word of a run is RAM[(base + k mod len) mod 4096].
    function automatic logic [31:0] model_word(int base, int lenf, int k);
        return ram_mem[(base + (k % lenf)) % 4096];
    endfunction

    // Index of the first captured sample that differs from the reference, -1 if none.
    function automatic int first_bad(int base, int lenf);
        for (int k = 0; k < got_q.size(); k++) begin
            if (got_q[k] !== model_word(base, lenf, k)) return k;
        end
        return -1;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        sample_ready = 1'b1;
        repeat (3) tick();
        tests_run++;
        if ({busy, sample_valid, ram_chipselect, ram_clken, done} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_ctl: busy/valid/cs/clken/done=%b, required 00000",
                     {busy, sample_valid, ram_chipselect, ram_clken, done});
        end
        tests_run++;
        if ({ram_address, sample_left, sample_right} !== 44'd0) begin
            tests_failed++;
            $display("FAIL reset_data: addr=%h L=%h R=%h, required all 0", ram_address, sample_left, sample_right);
        end
`ifdef PCM_STREAMER_UNDERRUN_CNT_EN
        tests_run++;
        if (underrun_cnt !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_urun: underrun_cnt=%0d, required 0", underrun_cnt);
        end
`endif
        start = 1'b0;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int bad;
        sample_ready = 1'b1;
        clear_logs();
        launch(12'd0, 12'd4, 1'b0);
        wait_idle(100, 1'b0, "basic");
        bad = first_bad(0, 4);
        tests_run++;
        if (got_q.size() != 4 || bad != -1) begin
            tests_failed++;
            $display("FAIL basic_seq: %0d samples, first bad idx %0d, required 4 samples matching words 0..3",
                     got_q.size(), bad);
        end
        tests_run++;
        if (done_cnt != 1) begin
            tests_failed++;
            $display("FAIL basic_done: %0d done pulses, required 1", done_cnt);
        end
    endtask

    task automatic test_wrap();
        int bad_a = -1;
        int bad;
        sample_ready = 1'b1;
        clear_logs();
        launch(12'd4094, 12'd4, 1'b0);
        wait_idle(100, 1'b0, "wrap");
        for (int k = 0; k < addr_q.size(); k++) begin
            if (addr_q[k] != (4094 + k) % 4096 && bad_a < 0) bad_a = k;
        end
        tests_run++;
        if (addr_q.size() != 4 || bad_a != -1) begin
            tests_failed++;
            $display("FAIL wrap_addr: %0d reads, first bad idx %0d, required 4094,4095,0,1", addr_q.size(), bad_a);
        end
        bad = first_bad(4094, 4);
        tests_run++;
        if (got_q.size() != 4 || bad != -1) begin
            tests_failed++;
            $display("FAIL wrap_seq: %0d samples, first bad idx %0d, required 4 matching", got_q.size(), bad);
        end
    endtask

    task automatic test_loop();
        int n = 0;
        int bad;
        sample_ready = 1'b1;
        clear_logs();
        launch(12'd0, 12'd3, 1'b1);
        while (got_q.size() < 12 && n < 200) begin
            tick();
            n++;
        end
        sample_ready = 1'b0;
        bad = first_bad(0, 3);
        tests_run++;
        if (got_q.size() != 12 || bad != -1) begin
            tests_failed++;
            $display("FAIL loop_seq: %0d samples, first bad idx %0d, required 12 = words 0,1,2 x4", got_q.size(), bad);
        end
        tests_run++;
        if (done_cnt != 0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL loop_state: done pulses %0d busy %b, required 0 and 1", done_cnt, busy);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_idle(10, 1'b0, "loop_stop");
    endtask

    task automatic test_backpressure();
        logic [11:0] b;
        int bad;
        b = 12'($urandom);
        sample_ready = 1'b0;
        clear_logs();
        launch(b, 12'd20, 1'b0);
        repeat (20) tick();
        tests_run++;
        if (addr_q.size() != DEPTH || ram_chipselect !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_issue: %0d reads cs=%b, required %0d reads cs=0", addr_q.size(), ram_chipselect, DEPTH);
        end
        sample_ready = 1'b1;
        wait_idle(200, 1'b0, "bp");
        bad = first_bad(int'(b), 20);
        tests_run++;
        if (got_q.size() != 20 || bad != -1) begin
            tests_failed++;
            $display("FAIL bp_seq: %0d samples, first bad idx %0d, required 20 matching", got_q.size(), bad);
        end
    endtask

    task automatic test_stop();
        logic [11:0] b;
        int bad;
        b = 12'($urandom);
        sample_ready = 1'b1;
        clear_logs();
        launch(b, 12'd100, 1'b0);
        repeat (3) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        tests_run++;
        if ({sample_valid, busy, ram_chipselect} !== 3'b000 || done_cnt != 0) begin
            tests_failed++;
            $display("FAIL stop_state: valid/busy/cs=%b done pulses %0d, required 000 and 0",
                     {sample_valid, busy, ram_chipselect}, done_cnt);
        end
        clear_logs();
        launch(b, 12'd5, 1'b0);
        wait_idle(100, 1'b0, "restart");
        bad = first_bad(int'(b), 5);
        tests_run++;
        if (got_q.size() != 5 || bad != -1 || done_cnt != 1) begin
            tests_failed++;
            $display("FAIL stop_replay: %0d samples first bad %0d done %0d, required 5 from base, 1 done",
                     got_q.size(), bad, done_cnt);
        end
    endtask

    task automatic test_start_stop_same();
        cfg_base = 12'd7;
        cfg_len  = 12'd3;
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        tick();
        tests_run++;
        if (busy !== 1'b0 || ram_chipselect !== 1'b0) begin
            tests_failed++;
            $display("FAIL start_stop: busy=%b cs=%b, required 0 0", busy, ram_chipselect);
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        sample_ready = 1'b0;
        launch(12'd100, 12'd50, 1'b0);
        repeat (6) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || sample_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid: busy=%b valid=%b, required 0 0", busy, sample_valid);
        end
        sample_ready = 1'b1;
        clear_logs();
        launch(12'd9, 12'd3, 1'b0);
        wait_idle(100, 1'b0, "post_reset");
        bad = first_bad(9, 3);
        tests_run++;
        if (got_q.size() != 3 || bad != -1) begin
            tests_failed++;
            $display("FAIL reset_stale: %0d samples first bad %0d, required 3 from word 9", got_q.size(), bad);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            logic [11:0] b;
            int l, bad;
            b = 12'($urandom);
            l = $urandom_range(1, 40);
            clear_logs();
            launch(b, 12'(l), 1'b0);
            wait_idle(2000, 1'b1, "random");
            sample_ready = 1'b1;
            bad = first_bad(int'(b), l);
            tests_run++;
            if (got_q.size() != l || bad != -1 || done_cnt != 1) begin
                tests_failed++;
                $display("FAIL random_%0d: base %0d len %0d got %0d samples first bad %0d done %0d, required %0d, -1, 1",
                         it, b, l, got_q.size(), bad, done_cnt, l);
            end
        end
    endtask

    task automatic test_len_zero();
        logic [11:0] b;
        int bad;
        b = 12'($urandom);
        sample_ready = 1'b1;
        clear_logs();
        launch(b, 12'd0, 1'b0);
        wait_idle(6000, 1'b0, "len0");
        bad = first_bad(int'(b), 4096);
        tests_run++;
        if (got_q.size() != 4096 || bad != -1) begin
            tests_failed++;
            $display("FAIL len0_seq: %0d samples first bad %0d, required 4096 matching", got_q.size(), bad);
        end
    endtask

`ifdef PCM_STREAMER_UNDERRUN_CNT_EN
    // From start with the sink ready, the FIFO is empty for exactly the issue and return clks.
    task automatic test_underrun();
        sample_ready = 1'b1;
        clear_logs();
        launch(12'd0, 12'd200, 1'b0);
        repeat (10) tick();
        tests_run++;
        if (underrun_cnt !== 16'd2) begin
            tests_failed++;
            $display("FAIL urun_first: underrun_cnt=%0d, required 2", underrun_cnt);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_idle(10, 1'b0, "urun");
        repeat (5) tick();
        launch(12'd0, 12'd200, 1'b0);
        repeat (10) tick();
        tests_run++;
        if (underrun_cnt !== 16'd2) begin
            tests_failed++;
            $display("FAIL urun_restart: underrun_cnt=%0d, required 2", underrun_cnt);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_idle(10, 1'b0, "urun2");
    endtask
`endif

    initial begin
        for (int i = 0; i < 4096; i++) begin
            ram_mem[i] = {16'(i), ~16'(i)};
        end
        test_reset();
        test_basic();
        test_wrap();
        test_loop();
        test_backpressure();
        test_stop();
        test_start_stop_same();
        test_reset_mid();
        test_random();
        test_len_zero();
`ifdef PCM_STREAMER_UNDERRUN_CNT_EN
        test_underrun();
`endif
        tests_run++;
        if (clken_bad != 0) begin
            tests_failed++;
            $display("FAIL clken: %0d clks with ram_clken != ram_chipselect, required 0", clken_bad);
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
